iq_demod_accum: RTL and testbench

- Receive-side counterpart of the impedance-excitation counter.
- The counter drives the DAC (P1..P5) and the in-phase/quadrature reference clocks.
- This block takes the 1-bit comparator response of the device under test and multiplies it by the IP and QP references (XNOR ±1). It accumulates the I and Q products over a programmed whole number of excitation periods.
- It presents signed I/Q sums with a one-cycle valid strobe to the readout logic.

---
 rtl/iq_demod_accum_if.sv | 25 ++
 rtl/iq_demod_accum.sv | 144 ++++++++++++++
 tb/tb_iq_demod_accum.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/iq_demod_accum_if.sv
// rtl/iq_demod_accum_if.sv - measurement request, reference/comparator inputs and I/Q result bus
interface iq_demod_accum_if #(
    parameter int ACC_W = 16
);
    logic                    Start;
    logic                    Sample;
    logic                    IP;
    logic                    QP;
    logic                    Busy;
    logic                    Valid;
    logic signed [ACC_W-1:0] I_out;
    logic signed [ACC_W-1:0] Q_out;
    logic                    Overflow;
    logic                    Error;

    modport master (
        output Start, Sample, IP, QP,
        input  Busy, Valid, I_out, Q_out, Overflow, Error
    );

    modport slave (
        input  Start, Sample, IP, QP,
        output Busy, Valid, I_out, Q_out, Overflow, Error
    );
endinterface

// File: rtl/iq_demod_accum.sv
// rtl/iq_demod_accum.sv - I/Q demodulating accumulator over a whole number of IP periods
module iq_demod_accum #(
    parameter int NPERIODS = 4,
    parameter int ACC_W    = 16,
    parameter int TIMEOUT  = 1024
) (
    input  logic             Clk,
    input  logic             Reset,
    iq_demod_accum_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT_EDGE, ACCUM, DONE} state_t;

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT - 1);
    localparam logic [7:0]    NLAST = 8'(NPERIODS - 1);
    localparam logic signed [ACC_W-1:0] ONE  = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = -MAXV;

    // Returns {saturated, next}; the range is symmetric so +/-1 products cannot bias a sum.
    function automatic logic [ACC_W:0] sat_step(input logic signed [ACC_W-1:0] acc, input logic up);
        if (up)
            return (acc == MAXV) ? {1'b1, acc} : {1'b0, acc + ONE};
        else
            return (acc == MINV) ? {1'b1, acc} : {1'b0, acc - ONE};
    endfunction

    state_t                  state_q, state_d;
    logic                    ip_q;
    logic [7:0]              cnt_q, cnt_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic signed [ACC_W-1:0] i_acc_q, i_acc_d, q_acc_q, q_acc_d;
    logic signed [ACC_W-1:0] i_out_q, i_out_d, q_out_q, q_out_d;
    logic                    ovf_q, ovf_d, ov_out_q, ov_out_d, err_q, err_d;
    logic                    acc_en;
    logic                    ip_edge;
    logic [ACC_W:0]          i_res, q_res;

    assign ip_edge = bus.IP & ~ip_q;
    assign i_res   = sat_step(i_acc_q, ~(bus.Sample ^ bus.IP));
    assign q_res   = sat_step(q_acc_q, ~(bus.Sample ^ bus.QP));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        i_acc_d  = i_acc_q;
        q_acc_d  = q_acc_q;
        i_out_d  = i_out_q;
        q_out_d  = q_out_q;
        ovf_d    = ovf_q;
        ov_out_d = ov_out_q;
        err_d    = err_q;
        acc_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    state_d = WAIT_EDGE;
                    cnt_d   = '0;
                    timer_d = '0;
                    i_acc_d = '0;
                    q_acc_d = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            WAIT_EDGE: begin
                if (ip_edge) begin
                    state_d = ACCUM;
                    timer_d = '0;
                    acc_en  = 1'b1;
                end else if (timer_q == TMAX) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ACCUM: begin
                if (ip_edge) begin
                    timer_d = '0;
                    if (cnt_q == NLAST) begin
                        // Closing edge starts the next period, so it is left out of the sums.
                        state_d  = DONE;
                        i_out_d  = i_acc_q;
                        q_out_d  = q_acc_q;
                        ov_out_d = ovf_q;
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        acc_en = 1'b1;
                    end
                end else if (timer_q == TMAX) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                    acc_en  = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (acc_en) begin
            i_acc_d = i_res[ACC_W-1:0];
            q_acc_d = q_res[ACC_W-1:0];
            ovf_d   = ovf_q | i_res[ACC_W] | q_res[ACC_W];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            ip_q     <= 1'b0;
            cnt_q    <= '0;
            timer_q  <= '0;
            i_acc_q  <= '0;
            q_acc_q  <= '0;
            i_out_q  <= '0;
            q_out_q  <= '0;
            ovf_q    <= 1'b0;
            ov_out_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ip_q     <= bus.IP;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            i_acc_q  <= i_acc_d;
            q_acc_q  <= q_acc_d;
            i_out_q  <= i_out_d;
            q_out_q  <= q_out_d;
            ovf_q    <= ovf_d;
            ov_out_q <= ov_out_d;
            err_q    <= err_d;
        end
    end

    assign bus.Busy     = (state_q != IDLE);
    assign bus.Valid    = (state_q == DONE);
    assign bus.I_out    = i_out_q;
    assign bus.Q_out    = q_out_q;
    assign bus.Overflow = ov_out_q;
    assign bus.Error    = err_q;
endmodule

// File: tb/tb_iq_demod_accum.sv
// tb/tb_iq_demod_accum.sv - directed bench for iq_demod_accum at three parameter sets
module tb_iq_demod_accum;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic start = 1'b0;
    logic sample = 1'b0;
    logic ip = 1'b0;
    logic qp = 1'b0;
    bit   ip_run = 1'b1;
    int   mode = 0;
    int   ph = 19;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int edge_cnt = 0;
    int last_edge_cyc = 0;
    logic ip_prev = 1'b0;

    int base, n_valid, edges_at_valid, busy_gap, err_at_accept;
    bit on_edge, busy_after;
    int i0, q0, ov0, i1, q1, ov1, i2, q2, ov2;

    always #5 Clk = ~Clk;

    iq_demod_accum_if #(.ACC_W(16)) if0 ();
    iq_demod_accum_if #(.ACC_W(6))  if1 ();
    iq_demod_accum_if #(.ACC_W(16)) if2 ();

    assign if0.Start = start;  assign if0.Sample = sample;  assign if0.IP = ip;  assign if0.QP = qp;
    assign if1.Start = start;  assign if1.Sample = sample;  assign if1.IP = ip;  assign if1.QP = qp;
    assign if2.Start = start;  assign if2.Sample = sample;  assign if2.IP = ip;  assign if2.QP = qp;

    iq_demod_accum #(.NPERIODS(4), .ACC_W(16), .TIMEOUT(64)) dut0 (.Clk(Clk), .Reset(Reset), .bus(if0));
    iq_demod_accum #(.NPERIODS(4), .ACC_W(6),  .TIMEOUT(64)) dut1 (.Clk(Clk), .Reset(Reset), .bus(if1));
    iq_demod_accum #(.NPERIODS(1), .ACC_W(16), .TIMEOUT(64)) dut2 (.Clk(Clk), .Reset(Reset), .bus(if2));

    // IP: 10 high / 10 low; QP: IP delayed by 5 cycles
    initial begin
        forever begin
            @(negedge Clk);
            if (ip_run) begin
                ph = (ph + 1) % 20;
                ip = (ph < 10);
                qp = (ph >= 5 && ph < 15);
            end else begin
                ph = 19;
                ip = 1'b0;
                qp = 1'b0;
            end
            case (mode)
                0: sample = ip;
                1: sample = ~ip;
                2: sample = qp;
                default: sample = 1'b1;
            endcase
        end
    end

    always @(posedge Clk) begin
        cyc     <= cyc + 1;
        ip_prev <= ip;
        if (ip && !ip_prev) begin
            edge_cnt      <= edge_cnt + 1;
            last_edge_cyc <= cyc + 1;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic measure(input int m, input bit hold, input bit poke);
        bit seen;
        int vk;
        mode = m;
        repeat (3) @(negedge Clk);
        start = 1'b1;
        @(posedge Clk); #1;
        base = edge_cnt;
        err_at_accept = int'(if0.Error);
        if (!hold) start = 1'b0;
        n_valid = 0; busy_gap = 0; busy_after = 1'b1; seen = 1'b0; vk = 0;
        edges_at_valid = -1; on_edge = 1'b0;
        if (!if0.Busy) busy_gap++;
        for (int k = 1; k <= 300; k++) begin
            @(posedge Clk); #1;
            if (seen && k == vk + 1) busy_after = if0.Busy;
            if (if0.Valid) begin
                n_valid++;
                if (n_valid == 1) begin
                    edges_at_valid = edge_cnt - base;
                    on_edge = (last_edge_cyc == cyc);
                    i0 = if0.I_out; q0 = if0.Q_out; ov0 = int'(if0.Overflow);
                    i1 = if1.I_out; q1 = if1.Q_out; ov1 = int'(if1.Overflow);
                    i2 = if2.I_out; q2 = if2.Q_out; ov2 = int'(if2.Overflow);
                    seen = 1'b1;
                    vk = k;
                end
            end else if (!seen && !if0.Busy) begin
                busy_gap++;
            end
            start = (hold && !seen) || (poke && (k == 30 || if0.Valid));
        end
        start = 1'b0;
        if (!seen) busy_gap = -1;
    endtask

    initial begin
        int s, delta, nv, busy_at;
        bit got;

        repeat (3) @(negedge Clk);
        check("rst_busy",  int'(if0.Busy), 0);
        check("rst_valid", int'(if0.Valid), 0);
        check("rst_i",     int'(if0.I_out), 0);
        check("rst_q",     int'(if0.Q_out), 0);
        check("rst_ovf",   int'(if0.Overflow), 0);
        check("rst_err",   int'(if0.Error), 0);
        Reset = 1'b0;

        measure(0, 1'b0, 1'b0);
        check("ip_nvalid",     n_valid, 1);
        check("ip_edges",      edges_at_valid, 5);
        check("ip_on_edge",    int'(on_edge), 1);
        check("ip_busy_gap",   busy_gap, 0);
        check("ip_busy_after", int'(busy_after), 0);
        check("ip_i",   i0, 80);
        check("ip_q",   q0, 0);
        check("ip_ovf", ov0, 0);
        check("w6_i",   i1, 31);
        check("w6_q",   q1, 0);
        check("w6_ovf", ov1, 1);
        check("n1_i",   i2, 20);
        check("n1_q",   q2, 0);
        check("n1_ovf", ov2, 0);

        measure(1, 1'b0, 1'b0);
        check("nip_i", i0, -80);
        check("nip_q", q0, 0);
        check("nip_n1_i", i2, -20);
        measure(2, 1'b0, 1'b0);
        check("qp_i", i0, 0);
        check("qp_q", q0, 80);
        measure(3, 1'b0, 1'b0);
        check("one_i", i0, 0);
        check("one_q", q0, 0);

        measure(0, 1'b1, 1'b0);
        check("hold_nvalid", n_valid, 1);
        check("hold_i", i0, 80);
        check("hold_busy_after", int'(busy_after), 0);
        measure(0, 1'b0, 1'b1);
        check("poke_nvalid", n_valid, 1);
        check("poke_i", i0, 80);
        check("poke_busy_after", int'(busy_after), 0);

        // asynchronous reset in the middle of a measurement
        mode = 0;
        @(negedge Clk); start = 1'b1;
        @(negedge Clk); start = 1'b0;
        repeat (40) @(posedge Clk);
        #3 Reset = 1'b1;
        #1;
        check("amid_busy", int'(if0.Busy), 0);
        check("amid_i",    int'(if0.I_out), 0);
        check("amid_valid", int'(if0.Valid), 0);
        @(negedge Clk); Reset = 1'b0;
        measure(0, 1'b0, 1'b0);
        check("after_rst_nvalid", n_valid, 1);
        check("after_rst_i", i0, 80);

        // IP stuck low -> timeout
        ip_run = 1'b0;
        repeat (3) @(negedge Clk);
        start = 1'b1;
        @(posedge Clk); #1;
        s = cyc;
        start = 1'b0;
        got = 1'b0; delta = -1; nv = 0; busy_at = -1;
        for (int k = 0; k < 100; k++) begin
            @(posedge Clk); #1;
            if (if0.Valid) nv++;
            if (if0.Error && !got) begin
                got = 1'b1;
                delta = cyc - s;
                busy_at = int'(if0.Busy);
            end
        end
        check("to_delta",  delta, 64);
        check("to_busy",   busy_at, 0);
        check("to_nvalid", nv, 0);
        check("to_sticky", int'(if0.Error), 1);
        ip_run = 1'b1;
        measure(0, 1'b0, 1'b0);
        check("to_clear", err_at_accept, 0);
        check("to_next_i", i0, 80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
